bist_sequencer: RTL and testbench

//  Sequences the BIST datapath around the 4-requester arbiter CUT (circuito06).
//  On start: resets the CUT, seeds the LFSR and clears the MISR, then runs a fixed

---
 rtl/bist_sequencer_pkg.sv | 24 ++
 rtl/bist_sequencer_cycle_counter.sv | 40 ++++
 rtl/bist_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bist_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bist_sequencer_pkg.sv
// rtl/bist_sequencer_pkg.sv - shared state encodings and defaults for the BIST sequencer
// Purpose: state encoding (3-bit binary, IDLE..DONE) and default signature
//          constants shared by the sequencer, MISR and BIST top.
// Ports:   none (package).
package bist_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_t;

  localparam int          DEFAULT_SIG_W      = 16;
  localparam logic [15:0] DEFAULT_GOLDEN_SIG = 16'h0000;

  // States in which a test is in progress: abort applies, start is ignored.
  function automatic logic is_active(input bist_state_t s);
    return (s == ST_INIT) || (s == ST_RUN) || (s == ST_FLUSH) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/bist_sequencer_cycle_counter.sv
// rtl/bist_sequencer_cycle_counter.sv - loadable down-counter with zero flag
// Purpose: times the INIT and RUN phases of the BIST sequencer.
// Ports:   clock_i/reset_i      clock, async active-high reset
//          load_i/load_value_i  load a new count (has priority over dec_i)
//          dec_i                decrement by one; saturates at zero
//          zero_o               count is zero
module bist_sequencer_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - BIST control FSM around the arbiter CUT
// Purpose: resets the CUT, seeds the LFSR, clears the MISR, runs PATTERN_COUNT
//          patterns, flushes the last response, compares the signature with
//          GOLDEN_SIG and reports bist_end_o / pass_fail_o.
// Ports:   clock_i, reset_i (async, active-high), start_i (rising edge),
//          abort_i, misr_signature_i[SIG_W]
//          test_mode_o, cut_reset_o, lfsr_load_o, lfsr_en_o, misr_clear_o,
//          misr_en_o, bist_end_o, pass_fail_o (all registered)
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter int               SIG_W         = DEFAULT_SIG_W,
  parameter int               PATTERN_COUNT = 1000,
  parameter int               INIT_CYCLES   = 2,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = SIG_W'(DEFAULT_GOLDEN_SIG)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SIG_W-1:0] misr_signature_i,
  output logic             test_mode_o,
  output logic             cut_reset_o,
  output logic             lfsr_load_o,
  output logic             lfsr_en_o,
  output logic             misr_clear_o,
  output logic             misr_en_o,
  output logic             bist_end_o,
  output logic             pass_fail_o
);

  localparam int CNT_MAX = (PATTERN_COUNT > INIT_CYCLES) ? PATTERN_COUNT : INIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  bist_state_t state_q, state_d;
  logic start_q, start_edge_q, start_edge_d;
  logic cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value;
  logic test_mode_d, cut_reset_d, lfsr_load_d, lfsr_en_d;
  logic misr_clear_d, misr_en_d, bist_end_d, pass_fail_d;
  logic test_mode_q, cut_reset_q, lfsr_load_q, lfsr_en_q;
  logic misr_clear_q, misr_en_q, bist_end_q, pass_fail_q;

  bist_sequencer_cycle_counter #(.WIDTH(CNT_W)) u_counter (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_value),
    .dec_i        (cnt_dec),
    .zero_o       (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    // The edge is registered so the FSM acts on it one cycle later; edges seen
    // while a test is running are dropped so they cannot trigger a rerun later.
    start_edge_d   = start_i & ~start_q & ~is_active(state_q);

    if (abort_i && is_active(state_q)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge_q) begin
            state_d        = ST_INIT;
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(INIT_CYCLES - 1);
          end
        end
        ST_INIT: begin
          if (cnt_zero) begin
            state_d        = ST_RUN;
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(PATTERN_COUNT - 1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_zero) begin
            state_d = ST_FLUSH;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_FLUSH: state_d = ST_CHECK;
        ST_CHECK: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so every register changes on the
    // same edge as the state itself.
    test_mode_d  = 1'b0;
    cut_reset_d  = 1'b0;
    lfsr_load_d  = 1'b0;
    lfsr_en_d    = 1'b0;
    misr_clear_d = 1'b0;
    misr_en_d    = 1'b0;
    bist_end_d   = 1'b0;
    pass_fail_d  = 1'b0;
    case (state_d)
      ST_INIT: begin
        test_mode_d  = 1'b1;
        cut_reset_d  = 1'b1;
        lfsr_load_d  = 1'b1;
        misr_clear_d = 1'b1;
      end
      ST_RUN: begin
        test_mode_d = 1'b1;
        lfsr_en_d   = 1'b1;
        misr_en_d   = 1'b1;
      end
      ST_FLUSH: begin
        test_mode_d = 1'b1;
        misr_en_d   = 1'b1;
      end
      ST_CHECK: test_mode_d = 1'b1;
      ST_DONE: begin
        bist_end_d  = 1'b1;
        // Compare is captured once on leaving CHECK, then held through DONE.
        pass_fail_d = (state_q == ST_CHECK) ? (misr_signature_i == GOLDEN_SIG) : pass_fail_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      start_edge_q <= 1'b0;
      test_mode_q  <= 1'b0;
      cut_reset_q  <= 1'b0;
      lfsr_load_q  <= 1'b0;
      lfsr_en_q    <= 1'b0;
      misr_clear_q <= 1'b0;
      misr_en_q    <= 1'b0;
      bist_end_q   <= 1'b0;
      pass_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_i;
      start_edge_q <= start_edge_d;
      test_mode_q  <= test_mode_d;
      cut_reset_q  <= cut_reset_d;
      lfsr_load_q  <= lfsr_load_d;
      lfsr_en_q    <= lfsr_en_d;
      misr_clear_q <= misr_clear_d;
      misr_en_q    <= misr_en_d;
      bist_end_q   <= bist_end_d;
      pass_fail_q  <= pass_fail_d;
    end
  end

  assign test_mode_o  = test_mode_q;
  assign cut_reset_o  = cut_reset_q;
  assign lfsr_load_o  = lfsr_load_q;
  assign lfsr_en_o    = lfsr_en_q;
  assign misr_clear_o = misr_clear_q;
  assign misr_en_o    = misr_en_q;
  assign bist_end_o   = bist_end_q;
  assign pass_fail_o  = pass_fail_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - self-checking bench for bist_sequencer
module tb_bist_sequencer;

  localparam int          PC       = 8;
  localparam int          IC       = 2;
  localparam logic [15:0] GOLD     = 16'hA5C3;
  localparam int          END_EDGE = 1 + IC + PC + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] misr_sig = 16'h0000;
  logic test_mode, cut_reset, lfsr_load, lfsr_en, misr_clear, misr_en, bist_end, pass_fail;
  logic [7:0] outs;

  typedef struct {
    int   end_edge;
    logic pass;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  bist_sequencer #(
    .SIG_W(16), .PATTERN_COUNT(PC), .INIT_CYCLES(IC), .GOLDEN_SIG(GOLD)
  ) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
    .misr_signature_i(misr_sig),
    .test_mode_o(test_mode), .cut_reset_o(cut_reset), .lfsr_load_o(lfsr_load),
    .lfsr_en_o(lfsr_en), .misr_clear_o(misr_clear), .misr_en_o(misr_en),
    .bist_end_o(bist_end), .pass_fail_o(pass_fail)
  );

  assign outs = {test_mode, cut_reset, lfsr_load, lfsr_en, misr_clear, misr_en, bist_end, pass_fail};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at edge 0; returns 1 time unit after edge 0.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows one run from edge 1 until bist_end, presenting sig on the MISR from FLUSH on.
  task automatic observe_run(input logic [15:0] sig, output int end_edge, output logic pf,
                             output int init_n, output int run_n, output int flush_n,
                             output logic e1_be, output logic e1_pf);
    end_edge = -1; pf = 1'b0; init_n = 0; run_n = 0; flush_n = 0; e1_be = 1'b1; e1_pf = 1'b1;
    misr_sig = 16'h0000;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin e1_be = bist_end; e1_pf = pass_fail; end
      if (test_mode && cut_reset && lfsr_load && misr_clear && !lfsr_en && !misr_en) init_n++;
      if (test_mode && lfsr_en && misr_en && !cut_reset) run_n++;
      if (test_mode && misr_en && !lfsr_en) begin flush_n++; misr_sig = sig; end
      if (bist_end) begin end_edge = n; pf = pass_fail; break; end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_outs: got %b expected 00000000", outs); end
    #2 rst = 1'b0;
    tick(); tick();
    n_cmp++; if (outs !== 8'h00) begin n_fail++; $display("FAIL idle_outs: got %b expected 00000000", outs); end
  endtask

  task automatic test_pass();
    int ee, ini, rn, fl; logic pf, b1, p1; exp_t e;
    start_pulse();
    exp_q.push_back('{END_EDGE, 1'b1});
    observe_run(GOLD, ee, pf, ini, rn, fl, b1, p1);
    e = exp_q.pop_front();
    n_cmp++; if (ee !== e.end_edge) begin n_fail++; $display("FAIL pass_end_edge: got %0d expected %0d", ee, e.end_edge); end
    n_cmp++; if (pf !== e.pass) begin n_fail++; $display("FAIL pass_result: got %0b expected %0b", pf, e.pass); end
    n_cmp++; if (ini !== IC) begin n_fail++; $display("FAIL pass_init_cycles: got %0d expected %0d", ini, IC); end
    n_cmp++; if (rn !== PC) begin n_fail++; $display("FAIL pass_run_cycles: got %0d expected %0d", rn, PC); end
    n_cmp++; if (fl !== 1) begin n_fail++; $display("FAIL pass_flush_cycles: got %0d expected 1", fl); end
    tick(); tick();
    n_cmp++; if ({bist_end, pass_fail} !== 2'b11) begin n_fail++; $display("FAIL pass_done_hold: got %b expected 11", {bist_end, pass_fail}); end
  endtask

  task automatic test_fail_sig();
    int ee, ini, rn, fl; logic pf, b1, p1; exp_t e;
    start_pulse();
    exp_q.push_back('{END_EDGE, 1'b0});
    observe_run(16'hA5C2, ee, pf, ini, rn, fl, b1, p1);
    e = exp_q.pop_front();
    n_cmp++; if (ee !== e.end_edge) begin n_fail++; $display("FAIL fail_end_edge: got %0d expected %0d", ee, e.end_edge); end
    n_cmp++; if (pf !== e.pass) begin n_fail++; $display("FAIL fail_result: got %0b expected %0b", pf, e.pass); end
  endtask

  task automatic test_hold_start();
    int inits = 0; int be_cnt = 0; logic prev_cr = 1'b0;
    misr_sig = 16'h0000;
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (n == 19) start = 1'b0;
      if (cut_reset && !prev_cr) inits++;
      prev_cr = cut_reset;
      if (n >= 1 && bist_end) be_cnt++;
      if (test_mode && misr_en && !lfsr_en) misr_sig = GOLD;
    end
    n_cmp++; if (inits !== 1) begin n_fail++; $display("FAIL hold_runs: got %0d expected 1", inits); end
    n_cmp++; if (be_cnt !== 30 - END_EDGE) begin n_fail++; $display("FAIL hold_done_cycles: got %0d expected %0d", be_cnt, 30 - END_EDGE); end
    n_cmp++; if ({bist_end, pass_fail} !== 2'b11) begin n_fail++; $display("FAIL hold_result: got %b expected 11", {bist_end, pass_fail}); end
  endtask

  task automatic test_abort();
    int run_seen = 0; logic any_out = 1'b0;
    int ee, ini, rn, fl; logic pf, b1, p1; exp_t e;
    tick(); tick();
    start_pulse();
    for (int n = 1; n <= 20 && run_seen < 4; n++) begin
      tick();
      if (lfsr_en) run_seen++;
    end
    n_cmp++; if (run_seen !== 4) begin n_fail++; $display("FAIL abort_reach_run: got %0d expected 4", run_seen); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (outs !== 8'h00) begin n_fail++; $display("FAIL abort_outs: got %b expected 00000000", outs); end
    for (int n = 0; n < 15; n++) begin
      tick();
      if (outs != 8'h00) any_out = 1'b1;
    end
    n_cmp++; if (any_out !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: got %0b expected 0", any_out); end
    start_pulse();
    exp_q.push_back('{END_EDGE, 1'b1});
    observe_run(GOLD, ee, pf, ini, rn, fl, b1, p1);
    e = exp_q.pop_front();
    n_cmp++; if (ee !== e.end_edge) begin n_fail++; $display("FAIL abort_rerun_edge: got %0d expected %0d", ee, e.end_edge); end
    n_cmp++; if (pf !== e.pass) begin n_fail++; $display("FAIL abort_rerun_result: got %0b expected %0b", pf, e.pass); end
  endtask

  task automatic test_reset_mid_run();
    int run_seen = 0;
    int ee, ini, rn, fl; logic pf, b1, p1; exp_t e;
    start_pulse();
    for (int n = 1; n <= 20 && run_seen < 2; n++) begin
      tick();
      if (lfsr_en) run_seen++;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (outs !== 8'h00) begin n_fail++; $display("FAIL async_reset_outs: got %b expected 00000000", outs); end
    #2 rst = 1'b0;
    tick(); tick();
    n_cmp++; if (outs !== 8'h00) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 00000000", outs); end
    start_pulse();
    exp_q.push_back('{END_EDGE, 1'b1});
    observe_run(GOLD, ee, pf, ini, rn, fl, b1, p1);
    e = exp_q.pop_front();
    n_cmp++; if (ee !== e.end_edge) begin n_fail++; $display("FAIL reset_rerun_edge: got %0d expected %0d", ee, e.end_edge); end
    n_cmp++; if (pf !== e.pass) begin n_fail++; $display("FAIL reset_rerun_result: got %0b expected %0b", pf, e.pass); end
  endtask

  task automatic test_restart();
    int ee, ini, rn, fl; logic pf, b1, p1; exp_t e;
    tick();
    n_cmp++; if ({bist_end, pass_fail} !== 2'b11) begin n_fail++; $display("FAIL restart_pre_done: got %b expected 11", {bist_end, pass_fail}); end
    start_pulse();
    exp_q.push_back('{END_EDGE, 1'b0});
    observe_run(16'h0000, ee, pf, ini, rn, fl, b1, p1);
    e = exp_q.pop_front();
    n_cmp++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL restart_clear_end: got %0b expected 0", b1); end
    n_cmp++; if (p1 !== 1'b0) begin n_fail++; $display("FAIL restart_clear_pf: got %0b expected 0", p1); end
    n_cmp++; if (ee !== e.end_edge) begin n_fail++; $display("FAIL restart_end_edge: got %0d expected %0d", ee, e.end_edge); end
    n_cmp++; if (pf !== e.pass) begin n_fail++; $display("FAIL restart_result: got %0b expected %0b", pf, e.pass); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_sig();
    test_hold_start();
    test_abort();
    test_reset_mid_run();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
